mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning data memory depth in 32-bit words (power of two).
REQ-002 SHALL have port clk, input, 1 bit, meaning rising-edge clock, the only clock in the block.
REQ-003 SHALL have port rst, input, 1 bit, meaning synchronous active-low reset.
REQ-004 SHALL have ports LoadMux_in and MemToReg_in, input, 2 bits each, meaning WB control from EX/MEM.
REQ-005 SHALL have port RegWrite_in, input, 1 bit, meaning WB register-write enable.
REQ-006 SHALL have ports MemWrite_in and MemRead_in, input, 1 bit each, meaning memory strobes.
REQ-007 SHALL have port StoreMux_in, input, 2 bits, meaning store width: 0 word, 1 half, 2 byte, 3 reserved (no write).
REQ-008 SHALL have ports ALUResult_in, RtContent_in and PCplus4_in, input, 32 bits each, meaning byte address, store data and link value.
REQ-009 SHALL have port RdAddress_in, input, 5 bits, meaning destination register.
REQ-010 SHALL have ports MemToReg_out (2 bits), RegWrite_out (1 bit), RdAddress_out (5 bits), ALUResult_out, ReadData_out and PCplus4_out (32 bits each), output, meaning MEM/WB register contents.
REQ-011 SHALL have port AddrErr_out, output, 1 bit, present only under MEM_ALIGN_CHECK_EN, meaning misaligned-access flag for the instruction now in WB.

Function
REQ-012 SHALL index memory with word = ALUResult_in[log2(MEM_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-013 SHALL write on the rising edge when MemWrite_in=1: word writes all 4 bytes; half writes the lanes selected by ALUResult_in[1] from RtContent_in[15:0]; byte writes lane ALUResult_in[1:0] from RtContent_in[7:0]; little-endian lanes.
REQ-014 SHALL read memory combinationally, select the lane with ALUResult_in[1:0], and extend by LoadMux_in: 0 word, 1 half sign-extended, 2 byte sign-extended, 3 byte zero-extended.
REQ-015 SHALL register the extended read data into ReadData_out at the same edge, giving 1-cycle latency from EX/MEM input to MEM/WB output.
REQ-016 SHALL drive ReadData_out to 0 when MemRead_in=0 at that edge.
REQ-017 SHALL, when MemRead_in and MemWrite_in are both 1, return the pre-write data and still perform the write.
REQ-018 SHALL make a store at edge N visible to a load presented in cycle N+1 (no forwarding stall required).
REQ-019 SHALL pass MemToReg, RegWrite, RdAddress, ALUResult and PCplus4 unchanged with 1-cycle latency.
REQ-020 SHALL hold no state other than the MEM/WB register and the memory array.

Reset
REQ-021 SHALL, on a rising edge with rst=0, clear every output to 0 (AddrErr_out included).
REQ-022 SHALL suppress any memory write on an edge where rst=0; memory contents are not cleared.
REQ-023 SHALL resume normal capture on the first edge with rst=1.

Configuration
REQ-024 SHALL, with MEM_ALIGN_CHECK_EN defined, treat a word access with ALUResult_in[1:0]!=0 or a half access with ALUResult_in[0]=1 as misaligned: the write is suppressed, RegWrite_out is forced to 0, and AddrErr_out=1 for that one cycle.
REQ-025 SHALL, without MEM_ALIGN_CHECK_EN, ignore ALUResult_in[1:0] for word accesses and ALUResult_in[0] for half accesses, omit AddrErr_out, and never alter RegWrite.

Structure
REQ-026 SHALL take StoreMux/LoadMux encodings and MemToReg encodings from the shared pipeline package pipe_pkg, alongside the EX/MEM definitions.
REQ-027 SHALL place the memory array with byte-lane write enables in the sub-module data_mem; lane selection, extension and the MEM/WB register stay in mem_wb_stage.

Verification
REQ-028 Store word 0xDEADBEEF at address 0x10, then load word at 0x10 next cycle -> ReadData_out=0xDEADBEEF one cycle later.
REQ-029 Store byte 0x80 at 0x13, then lb at 0x13 -> 0xFFFFFF80; lbu at 0x13 -> 0x00000080; lw at 0x10 -> 0x80ADBEEF.
REQ-030 Store half 0x1234 at 0x22, then lh at 0x22 -> 0x00001234; lw at 0x20 -> 0x1234xxxx (lower half unchanged).
REQ-031 Drive rst=0 while MemWrite_in=1 to 0x30 with 0x55 -> all outputs 0; a later lw at 0x30 returns the prior contents.
REQ-032 Enable MemRead_in and MemWrite_in together at 0x40 (old 0x1, new 0x2) -> ReadData_out=0x1; next lw at 0x40 returns 0x2.
REQ-033 With MEM_ALIGN_CHECK_EN, perform lw at 0x41 with RegWrite_in=1 -> AddrErr_out=1 and RegWrite_out=0 for one cycle; sw at 0x42 leaves memory unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX/MEM and MEM/WB bundles, mux encodings, load-extend helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a; the pipeline stages that use these types never stall.
package pipe_pkg;

   // Store width selected in EX, consumed by the MEM stage write path
   typedef enum logic [1:0] {
      ST_WORD = 2'd0,
      ST_HALF = 2'd1,
      ST_BYTE = 2'd2,
      ST_RSVD = 2'd3
   } storeMux_e;

   // Load width / extension applied to the raw memory word
   typedef enum logic [1:0] {
      LD_WORD  = 2'd0,
      LD_HALF  = 2'd1,
      LD_BYTE  = 2'd2,
      LD_BYTEU = 2'd3
   } loadMux_e;

   // Write-back source selected in WB
   typedef enum logic [1:0] {
      MTR_ALU  = 2'd0,
      MTR_MEM  = 2'd1,
      MTR_PC4  = 2'd2,
      MTR_RSVD = 2'd3
   } memToReg_e;

   // EX/MEM register contents as produced by the execute stage
   typedef struct packed {
      logic [1:0]  loadMux;
      logic [1:0]  memToReg;
      logic        regWrite;
      logic        memWrite;
      logic        memRead;
      logic [1:0]  storeMux;
      logic [31:0] aluResult;
      logic [31:0] rtContent;
      logic [31:0] pcPlus4;
      logic [4:0]  rdAddress;
   } exMem_t;

   // MEM/WB register contents handed to the write-back stage
   typedef struct packed {
      logic [1:0]  memToReg;
      logic        regWrite;
      logic [4:0]  rdAddress;
      logic [31:0] aluResult;
      logic [31:0] readData;
      logic [31:0] pcPlus4;
   } memWb_t;

   // Pick the addressed lane out of a little-endian word and extend it.
   // Halves use only lane[1]; the low address bit is deliberately ignored.
   function automatic logic [31:0] loadExtend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  loadMux);
      logic [15:0] half;
      logic [7:0]  byteVal;
      half    = lane[1] ? word[31:16] : word[15:0];
      byteVal = word[8*lane +: 8];
      case (loadMux)
         LD_WORD: loadExtend = word;
         LD_HALF: loadExtend = {{16{half[15]}}, half};
         LD_BYTE: loadExtend = {{24{byteVal[7]}}, byteVal};
         default: loadExtend = {24'd0, byteVal};
      endcase
   endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: MEM_WORDS x 32-bit array, per-byte-lane write enables, combinational read.
// Latency: read is combinational; a write lands on the rising edge and is readable the next cycle.
// Backpressure: none, one access per cycle always accepted.
module data_mem
   import pipe_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] wordAddr,
   input  logic [3:0]        laneWe,
   input  logic [31:0]       wrData,
   output logic [31:0]       rdData
);

   logic [3:0][7:0] memArray [MEM_WORDS];

   // Byte-lane write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (laneWe[i]) begin
            memArray[wordAddr][i] <= wrData[8*i +: 8];
         end
      end
   end

   // Asynchronous read returns pre-write data during a same-cycle write
   assign rdData = memArray[wordAddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: data-memory store/load with lane select/extend; MEM_ALIGN_CHECK_EN adds misalignment trap.
// Latency: 1 cycle from EX/MEM inputs to MEM/WB outputs; stores visible to loads on the next cycle.
// Backpressure: none, a new instruction is accepted every cycle.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  LoadMux_in,
   input  logic [1:0]  MemToReg_in,
   input  logic        RegWrite_in,
   input  logic        MemWrite_in,
   input  logic        MemRead_in,
   input  logic [1:0]  StoreMux_in,
   input  logic [31:0] ALUResult_in,
   input  logic [31:0] RtContent_in,
   input  logic [31:0] PCplus4_in,
   input  logic [4:0]  RdAddress_in,
   output logic [1:0]  MemToReg_out,
   output logic        RegWrite_out,
   output logic [4:0]  RdAddress_out,
   output logic [31:0] ALUResult_out,
   output logic [31:0] ReadData_out,
   output logic [31:0] PCplus4_out
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        AddrErr_out
`endif
);

   localparam int ADDR_W = $clog2(MEM_WORDS);

   logic [ADDR_W-1:0] wordAddr;
   logic [3:0]        laneWe;
   logic [31:0]       wrData;
   logic [31:0]       rdData;
   logic              misaligned;
   memWb_t            memWbD;
   memWb_t            memWbQ;

   // Upper address bits are dropped so accesses wrap around the array
   assign wordAddr = ALUResult_in[ADDR_W+1:2];

   // Flag word accesses off a word boundary and half accesses off a half boundary
   always_comb begin
      misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if (MemRead_in) begin
         if ((LoadMux_in == LD_WORD) && (ALUResult_in[1:0] != 2'b00)) misaligned = 1'b1;
         if ((LoadMux_in == LD_HALF) && ALUResult_in[0])              misaligned = 1'b1;
      end
      if (MemWrite_in) begin
         if ((StoreMux_in == ST_WORD) && (ALUResult_in[1:0] != 2'b00)) misaligned = 1'b1;
         if ((StoreMux_in == ST_HALF) && ALUResult_in[0])              misaligned = 1'b1;
      end
`endif
   end

   // Store lane enables and replicated store data; reset and traps suppress the write
   always_comb begin
      laneWe = 4'b0000;
      wrData = RtContent_in;
      case (StoreMux_in)
         ST_WORD: begin
            laneWe = 4'b1111;
            wrData = RtContent_in;
         end
         ST_HALF: begin
            laneWe = ALUResult_in[1] ? 4'b1100 : 4'b0011;
            wrData = {2{RtContent_in[15:0]}};
         end
         ST_BYTE: begin
            laneWe = 4'b0001 << ALUResult_in[1:0];
            wrData = {4{RtContent_in[7:0]}};
         end
         default: laneWe = 4'b0000;
      endcase
      if (!rst || !MemWrite_in || misaligned) laneWe = 4'b0000;
   end

   data_mem #(
      .MEM_WORDS (MEM_WORDS)
   ) u_dataMem (
      .clk      (clk),
      .wordAddr (wordAddr),
      .laneWe   (laneWe),
      .wrData   (wrData),
      .rdData   (rdData)
   );

   // Next MEM/WB contents: pass-through fields plus extended load data
   always_comb begin
      memWbD           = '0;
      memWbD.memToReg  = MemToReg_in;
      memWbD.regWrite  = RegWrite_in && !misaligned;
      memWbD.rdAddress = RdAddress_in;
      memWbD.aluResult = ALUResult_in;
      memWbD.readData  = MemRead_in ? loadExtend(rdData, ALUResult_in[1:0], LoadMux_in) : 32'd0;
      memWbD.pcPlus4   = PCplus4_in;
   end

   // MEM/WB pipeline register with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst) begin
         memWbQ <= '0;
      end else begin
         memWbQ <= memWbD;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic addrErrQ;

   // Trap flag lives for exactly the one cycle the faulting instruction sits in WB
   always_ff @(posedge clk) begin
      if (!rst) begin
         addrErrQ <= 1'b0;
      end else begin
         addrErrQ <= misaligned;
      end
   end

   assign AddrErr_out = addrErrQ;
`endif

   assign MemToReg_out  = memWbQ.memToReg;
   assign RegWrite_out  = memWbQ.regWrite;
   assign RdAddress_out = memWbQ.rdAddress;
   assign ALUResult_out = memWbQ.aluResult;
   assign ReadData_out  = memWbQ.readData;
   assign PCplus4_out   = memWbQ.pcPlus4;

endmodule
